// File: rtl/sr_round_if.sv
// Handshake and data bundle for the stochastic-rounding stage: upstream
// operand/RNG side plus downstream result side.
interface sr_round_if #(
    parameter int IN_W  = 28,
    parameter int OUT_W = 24,
    parameter int EXP_W = 8
);
    localparam int R = IN_W - OUT_W;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_mant;
    logic [EXP_W-1:0] in_exp;
    logic             in_trunc;
    logic [R-1:0]     rnd;
    logic             rng_next;

    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_mant;
    logic [EXP_W-1:0] out_exp;
    logic             out_ovf;

    modport master (
        output in_valid, in_mant, in_exp, in_trunc, rnd, out_ready,
        input  in_ready, rng_next, out_valid, out_mant, out_exp, out_ovf
    );

    modport slave (
        input  in_valid, in_mant, in_exp, in_trunc, rnd, out_ready,
        output in_ready, rng_next, out_valid, out_mant, out_exp, out_ovf
    );
endinterface

// File: rtl/sr_round_stage.sv
// Two-stage stochastic/truncating mantissa rounder with exponent overflow.
// Optional statistics counters are built when SR_ROUND_STATS_EN is defined.
module sr_round_stage #(
    parameter int IN_W  = 28,
    parameter int OUT_W = 24,
    parameter int EXP_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    sr_round_if.slave   bus,
    output logic [15:0] up_count,
    output logic [15:0] total_count
);
    localparam int R = IN_W - OUT_W;
    localparam logic [EXP_W-1:0] EXP_MAX     = '1;
    localparam logic [EXP_W-1:0] EXP_PRE_MAX = EXP_MAX - 1'b1;

    logic             s1_valid, s2_valid;
    logic             s1_advance, in_ready_int, accept, out_fire;
    logic             carry;
    logic [OUT_W:0]   up_next;
    logic [OUT_W:0]   s1_up;
    logic [EXP_W-1:0] s1_exp;
    logic [OUT_W-1:0] norm_mant, out_mant_q;
    logic [EXP_W-1:0] norm_exp, out_exp_q;
    logic             norm_ovf, out_ovf_q;

    assign s1_advance   = !s2_valid || bus.out_ready;
    assign in_ready_int = !s1_valid || s1_advance;
    assign bus.in_ready = in_ready_int && !reset;
    assign accept       = bus.in_valid && bus.in_ready;
    assign bus.rng_next = accept && !bus.in_trunc;
    assign bus.out_valid = s2_valid;
    assign out_fire     = s2_valid && bus.out_ready;

    assign bus.out_mant = out_mant_q;
    assign bus.out_exp  = out_exp_q;
    assign bus.out_ovf  = out_ovf_q;

    // Carry out of in_mant[R-1:0] + rnd: the R-bit sum overflows exactly when a > ~b.
    always_comb begin
        carry   = (bus.in_mant[R-1:0] > ~bus.rnd) && !bus.in_trunc;
        up_next = {1'b0, bus.in_mant[IN_W-1:R]} + {{OUT_W{1'b0}}, carry};
    end

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        norm_mant = s1_up[OUT_W-1:0];
        norm_exp  = s1_exp;
        norm_ovf  = 1'b0;
        if (s1_exp == EXP_MAX || (s1_up[OUT_W] && s1_exp == EXP_PRE_MAX)) begin
            norm_mant = '0;
            norm_exp  = EXP_MAX;
            norm_ovf  = 1'b1;
        end else if (s1_up[OUT_W]) begin
            norm_mant = s1_up[OUT_W:1];
            norm_exp  = s1_exp + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            out_mant_q <= '0;
            out_exp_q  <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            if (in_ready_int) s1_valid <= bus.in_valid;
            if (s1_advance)   s2_valid <= s1_valid;
            if (s1_valid && s1_advance) begin
                out_mant_q <= norm_mant;
                out_exp_q  <= norm_exp;
                out_ovf_q  <= norm_ovf;
            end
        end
    end

    // NOTE: S1 payload is not reset; it is only ever consumed while s1_valid is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_up  <= up_next;
            s1_exp <= bus.in_exp;
        end
    end

`ifdef SR_ROUND_STATS_EN
    logic s1_c, s1_stoch, s2_c, s2_stoch;

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_c     <= carry;
            s1_stoch <= !bus.in_trunc;
        end
        if (s1_valid && s1_advance) begin
            s2_c     <= s1_c;
            s2_stoch <= s1_stoch;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            up_count    <= '0;
            total_count <= '0;
        end else if (out_fire && s2_stoch) begin
            if (total_count != 16'hFFFF) total_count <= total_count + 16'd1;
            if (s2_c && up_count != 16'hFFFF) up_count <= up_count + 16'd1;
        end
    end
`else
    assign up_count    = '0;
    assign total_count = '0;
`endif
endmodule

// File: tb/tb_sr_round_stage.sv
// Directed self-checking bench for sr_round_stage (default parameters);
// counter expectations follow whether SR_ROUND_STATS_EN is defined.
module tb_sr_round_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] up_count, total_count;
    int          n_tests = 0;
    int          n_fail  = 0;

    sr_round_if #(.IN_W(28), .OUT_W(24), .EXP_W(8)) bus ();

    sr_round_stage #(.IN_W(28), .OUT_W(24), .EXP_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .up_count    (up_count),
        .total_count (total_count)
    );

    always #5 clk = ~clk;

`ifdef SR_ROUND_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [27:0] m, input logic [7:0] e,
                         input logic t, input logic [3:0] r);
        bus.in_valid = v;
        bus.in_mant  = m;
        bus.in_exp   = e;
        bus.in_trunc = t;
        bus.rnd      = r;
        #1;
    endtask

    // One isolated transaction: accept, check 2-cycle latency and result, drain.
    task automatic run_one(input string tag, input logic [27:0] m, input logic [7:0] e,
                           input logic t, input logic [3:0] r, input logic [23:0] x_mant,
                           input logic [7:0] x_exp, input logic x_ovf);
        drive(1'b1, m, e, t, r);
        check({tag, ".ready"}, bus.in_ready, 1);
        check({tag, ".rng"}, bus.rng_next, !t);
        tick();
        drive(1'b0, '0, '0, 1'b0, '0);
        check({tag, ".rng_once"}, bus.rng_next, 0);
        check({tag, ".lat1"}, bus.out_valid, 0);
        tick();
        check({tag, ".lat2"}, bus.out_valid, 1);
        check({tag, ".mant"}, bus.out_mant, x_mant);
        check({tag, ".exp"}, bus.out_exp, x_exp);
        check({tag, ".ovf"}, bus.out_ovf, x_ovf);
        tick();
        check({tag, ".drain"}, bus.out_valid, 0);
    endtask

    initial begin
        int idx;
        int nout;
        int prev;
        bus.out_ready = 1'b1;

        // Reset: inputs offered but ignored, all state cleared.
        reset = 1'b1;
        drive(1'b1, 28'h0000018, 8'h10, 1'b0, 4'h7);
        tick();
        tick();
        check("rst.in_ready", bus.in_ready, 0);
        check("rst.rng_next", bus.rng_next, 0);
        check("rst.out_valid", bus.out_valid, 0);
        check("rst.out_mant", bus.out_mant, 0);
        check("rst.out_exp", bus.out_exp, 0);
        check("rst.out_ovf", bus.out_ovf, 0);
        check("rst.up", up_count, 0);
        check("rst.total", total_count, 0);
        drive(1'b0, '0, '0, 1'b0, '0);
        reset = 1'b0;
        #1;
        check("rst.ready_after", bus.in_ready, 1);
        tick();

        run_one("a_r7",    28'h0000018, 8'h10, 1'b0, 4'h7, 24'h000001, 8'h10, 1'b0);
        run_one("b_r8",    28'h0000018, 8'h10, 1'b0, 4'h8, 24'h000002, 8'h10, 1'b0);
        run_one("c_trunc", 28'h0000018, 8'h10, 1'b1, 4'h8, 24'h000001, 8'h10, 1'b0);
        run_one("d_wrap",  28'hFFFFFFF, 8'h10, 1'b0, 4'h1, 24'h800000, 8'h11, 1'b0);
        run_one("e_ovf",   28'hFFFFFFF, 8'hFE, 1'b0, 4'h1, 24'h000000, 8'hFF, 1'b1);
        run_one("f_expff", 28'h0000018, 8'hFF, 1'b0, 4'h0, 24'h000000, 8'hFF, 1'b1);
        run_one("g_exact", 28'h0000020, 8'h33, 1'b0, 4'hF, 24'h000002, 8'h33, 1'b0);

        // Back-pressure: only two fit, output holds, then drains in order at 1/cycle.
        bus.out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            drive(idx < 4, 28'((idx + 1) * 16), 8'h20, 1'b1, 4'h0);
            if (bus.in_valid && bus.in_ready) idx++;
            if (c >= 2) check("bp.hold", bus.out_mant, 1);
            tick();
        end
        drive(idx < 4, 28'((idx + 1) * 16), 8'h20, 1'b1, 4'h0);
        check("bp.accepted", idx, 2);
        check("bp.in_ready", bus.in_ready, 0);
        check("bp.out_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        nout = 0;
        prev = 0;
        for (int c = 0; c < 12 && nout < 4; c++) begin
            drive(idx < 4, 28'((idx + 1) * 16), 8'h20, 1'b1, 4'h0);
            if (bus.out_valid && bus.out_ready) begin
                check("bp.order", bus.out_mant, nout + 1);
                if (nout > 0) check("bp.rate", c, prev + 1);
                prev = c;
                nout++;
            end
            if (bus.in_valid && bus.in_ready) idx++;
            tick();
        end
        check("bp.count", nout, 4);
        drive(1'b0, '0, '0, 1'b0, '0);
        tick();

        // Stochastic transfers so far: a,b,d,e,f,g; round-ups: b,d,e.
        check("cnt.total6", total_count, STATS ? 6 : 0);
        check("cnt.up3", up_count, STATS ? 3 : 0);

        // Reset with both stages full discards everything.
        bus.out_ready = 1'b0;
        drive(1'b1, 28'h0000018, 8'h10, 1'b0, 4'h8);
        tick();
        tick();
        check("rf.full_ready", bus.in_ready, 0);
        check("rf.full_valid", bus.out_valid, 1);
        drive(1'b0, '0, '0, 1'b0, '0);
        reset = 1'b1;
        tick();
        check("rf.out_valid", bus.out_valid, 0);
        check("rf.in_ready", bus.in_ready, 0);
        check("rf.up", up_count, 0);
        check("rf.total", total_count, 0);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("rf.ready_after", bus.in_ready, 1);
        tick();
        tick();
        check("rf.discarded", bus.out_valid, 0);

        // Statistics: 10 stochastic (3 round up) plus one truncating.
        for (int i = 0; i < 10; i++) begin
            if (i % 3 == 0 && i < 9)
                run_one("s_up", 28'h0000018, 8'h40, 1'b0, 4'h8, 24'h000002, 8'h40, 1'b0);
            else
                run_one("s_dn", 28'h0000018, 8'h40, 1'b0, 4'h7, 24'h000001, 8'h40, 1'b0);
        end
        run_one("s_tr", 28'h0000018, 8'h40, 1'b1, 4'h8, 24'h000001, 8'h40, 1'b0);
        check("cnt.total10", total_count, STATS ? 10 : 0);
        check("cnt.up3b", up_count, STATS ? 3 : 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sr_round_stage.md
SR_ROUND_STAGE -- requirements
Module: sr_round_stage

Interface
REQ-001 Parameter IN_W, default 28: input mantissa width, including the bits to be discarded.
REQ-002 Parameter OUT_W, default 24: rounded mantissa width; R = IN_W-OUT_W (R >= 1) is the round-bit count and matches the random source's num_round_bits.
REQ-003 Parameter EXP_W, default 8: exponent width.
REQ-004 clk  input  1  the only clock; all state is updated on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid / in_ready  input / output  1 each  upstream valid/ready handshake.
REQ-007 in_mant  input  IN_W  unrounded mantissa.
REQ-008 in_exp  input  EXP_W  biased exponent.
REQ-009 in_trunc  input  1  1 = round toward zero; 0 = stochastic rounding.
REQ-010 rnd  input  R  random value from the RNG, combinational.
REQ-011 rng_next  output  1  advances the RNG; drives its get_next_val.
REQ-012 out_valid / out_ready  output / input  1 each  downstream handshake.
REQ-013 out_mant  output  OUT_W  rounded mantissa.
REQ-014 out_exp  output  EXP_W  result exponent.
REQ-015 out_ovf  output  1  exponent overflow; result forced to infinity.
REQ-016 up_count / total_count  output  16 each  statistics counters (see Configuration).

Function
REQ-017 The block SHALL be a two-stage pipeline: S1 captures the input and computes the add; S2 normalises and holds the output. Latency is 2 cycles from input accept to out_valid with no stall.
REQ-018 An input is accepted when in_valid && in_ready; in_ready = !s1_valid || s1_advance, where s1_advance = !s2_valid || out_ready.
REQ-019 An output transfers when out_valid && out_ready; out_valid = s2_valid.
REQ-020 S2 holds out_mant, out_exp and out_ovf stable while out_valid && !out_ready.
REQ-021 rng_next SHALL equal in_valid && in_ready && !in_trunc, so exactly one RNG advance happens per stochastic accept.
REQ-022 rnd is sampled in the same cycle as the accept; rnd is not used in any other cycle.
REQ-023 S1 computes {c, low_sum} = in_mant[R-1:0] + rnd, an (R+1)-bit sum with carry c. In trunc mode, c = 0.
REQ-024 S1 stores up = in_mant[IN_W-1:R] + c as an (OUT_W+1)-bit value, together with in_exp and c.
REQ-025 S2, if up[OUT_W] = 0: out_mant = up[OUT_W-1:0] and out_exp = exp.
REQ-026 S2, if up[OUT_W] = 1 (mantissa wrap): out_mant = up[OUT_W:1] and out_exp = exp+1.
REQ-027 If the mantissa wraps and exp = 2^EXP_W-2, or if exp = 2^EXP_W-1 on input: out_exp = all-ones, out_mant = 0, out_ovf = 1. Otherwise out_ovf = 0.
REQ-028 When in_mant[R-1:0] = 0, the result is exact: c = 0 for every rnd value, but rng_next still pulses.
REQ-029 When a new input is accepted and an output is taken in the same cycle, both transfers SHALL occur and throughput is 1 per cycle.

Reset
REQ-030 While reset = 1 at a clock edge: s1_valid = s2_valid = 0, out_mant = 0, out_exp = 0, out_ovf = 0, and both counters = 0.
REQ-031 While reset = 1: in_ready = 0 and rng_next = 0. Data in flight is discarded with no output.
REQ-032 in_ready SHALL be 1 on the first cycle after reset deasserts.

Configuration
REQ-033 With SR_ROUND_STATS_EN defined: total_count increments on each stochastic output transfer.
REQ-034 With SR_ROUND_STATS_EN defined: up_count increments on each stochastic output transfer that had c = 1.
REQ-035 With SR_ROUND_STATS_EN defined: both counters saturate at 16'hFFFF.
REQ-036 With SR_ROUND_STATS_EN undefined: no counter registers exist, and up_count = total_count = 0 constantly.

Verification (defaults IN_W=28, OUT_W=24, EXP_W=8)
REQ-037 Directed case: in_mant=28'h0000018, rnd=4'h7, exp=8'h10, stochastic -> out_mant=24'h000001, out_exp=8'h10, rng_next pulses once, out_valid 2 cycles later.
REQ-038 Directed case: in_mant=28'h0000018, rnd=4'h8 -> out_mant=24'h000002; the same input with in_trunc=1 -> out_mant=24'h000001 and rng_next=0.
REQ-039 Directed case: in_mant=28'hFFFFFFF, rnd=4'h1, exp=8'h10 -> out_mant=24'h800000, out_exp=8'h11. With exp=8'hFE -> out_exp=8'hFF, out_mant=0, out_ovf=1.
REQ-040 Directed case: stream 4 inputs with out_ready=0 -> exactly 2 are accepted, in_ready=0, and out_mant is stable. Then out_ready=1 -> all 4 emerge in order at 1 per cycle.
REQ-041 Directed case: assert reset with both stages full -> the next cycle has out_valid=0, in_ready=0, and both counters 0.
REQ-042 Directed case: with SR_ROUND_STATS_EN, 10 stochastic outputs of which 3 round up -> total_count=10, up_count=3. With the macro undefined, both counters read 0.
